firebird7_in_gate1_tessent_data_mux_sync: RTL and testbench

Multi-channel, update-synchronised IJTAG data override mux for the gate1 instrument cluster. Each channel selects between live functional data and a shadow copy of IJTAG data. Selection changes take effect only through an update-enable capture followed by a break-before-make settle window, so downstream logic never sees a mid-update mix. It is the parametrised successor of the per-bus combinational data mux and sits between the TDR parallel outputs and the functional destination.

---
 rtl/firebird7_in_gate1_data_mux_pkg.sv | 20 ++
 rtl/firebird7_in_gate1_data_mux_chan.sv | 117 +++++++++++
 rtl/firebird7_in_gate1_tessent_data_mux_sync.sv | 61 ++++++
 tb/tb_firebird7_in_gate1_tessent_data_mux_sync.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_data_mux_pkg.sv
// Shared definitions for the gate1 IJTAG data override mux:
// the per-channel state encoding and the settle-counter width helper.
package firebird7_in_gate1_data_mux_pkg;

  // Per-channel mux state. Settle states sit between the two stable states
  // so a select change never exposes a mix of old and new data.
  typedef enum logic [1:0] {
    FUNC     = 2'd0,
    TO_IJTAG = 2'd1,
    IJTAG    = 2'd2,
    TO_FUNC  = 2'd3
  } state_t;

  // Width of the settle counter. It must hold values up to SETTLE_CYCLES-1.
  // Sizing it for SETTLE_CYCLES+1 values keeps it at least one bit wide.
  function automatic int cnt_width(input int settle_cycles);
    return $clog2(settle_cycles + 1);
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_data_mux_chan.sv
// One channel of the gate1 IJTAG data override mux: the select FSM,
// the settle counter, the optional hold register and the output select.
// Optional feature macro: FIREBIRD7_IN_GATE1_DATA_MUX_HOLD_EN
//   defined     -> the last stable value is driven during settle windows
//   not defined -> zero is driven during settle windows (no hold register)
module firebird7_in_gate1_data_mux_chan
  import firebird7_in_gate1_data_mux_pkg::*;
#(
  parameter int WIDTH         = 19,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             shadow_sel,
  input  logic [WIDTH-1:0] shadow_data,
  input  logic [WIDTH-1:0] functional_data,
  output logic [WIDTH-1:0] data_out,
  output logic             active,
  output logic             settling
);

  localparam int              CNT_W    = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] settle_value;

  // Select FSM and settle counter. A settle window always runs to completion;
  // the stable target state re-evaluates shadow_sel on the following edge.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state <= FUNC;
      cnt   <= '0;
    end else begin
      case (state)
        FUNC: begin
          if (shadow_sel) begin
            state <= TO_IJTAG;
            cnt   <= CNT_LOAD;
          end
        end
        TO_IJTAG: begin
          if (cnt == '0) begin
            state <= IJTAG;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        IJTAG: begin
          if (!shadow_sel) begin
            state <= TO_FUNC;
            cnt   <= CNT_LOAD;
          end
        end
        TO_FUNC: begin
          if (cnt == '0) begin
            state <= FUNC;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= FUNC;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_HOLD_EN
  logic [WIDTH-1:0] hold;

  // Capture the value being driven at the moment a settle window opens,
  // so the settle window keeps showing the last stable output.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      hold <= '0;
    end else if (state == FUNC && shadow_sel) begin
      hold <= functional_data;
    end else if (state == IJTAG && !shadow_sel) begin
      hold <= shadow_data;
    end
  end

  // Settle windows replay the held value.
  always_comb begin
    settle_value = hold;
  end
`else
  // Settle windows drive a forced-quiet gap.
  always_comb begin
    settle_value = '0;
  end
`endif

  // Output select: live data in FUNC, registered shadow in IJTAG,
  // the settle value while switching.
  always_comb begin
    data_out = functional_data;
    case (state)
      FUNC:     data_out = functional_data;
      IJTAG:    data_out = shadow_data;
      TO_IJTAG: data_out = settle_value;
      TO_FUNC:  data_out = settle_value;
      default:  data_out = functional_data;
    endcase
  end

  // Status flags for the top-level reduction.
  always_comb begin
    active   = (state == IJTAG);
    settling = (state == TO_IJTAG) || (state == TO_FUNC);
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync.sv
// Multi-channel, update-synchronised IJTAG data override mux for the gate1
// instrument cluster. It holds the shadow registers loaded on ijtag_ue and
// one select FSM per channel. busy reports any channel inside a settle window.
// Optional feature macro: FIREBIRD7_IN_GATE1_DATA_MUX_HOLD_EN
//   (hold the last stable value during settle windows instead of zero).
module firebird7_in_gate1_tessent_data_mux_sync
  import firebird7_in_gate1_data_mux_pkg::*;
#(
  parameter int WIDTH         = 19,
  parameter int CHANNELS      = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                      ijtag_tck,
  input  logic                      ijtag_reset,
  input  logic                      ijtag_ue,
  input  logic [CHANNELS-1:0]       ijtag_select_in,
  input  logic [CHANNELS*WIDTH-1:0] ijtag_data_in,
  input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       ijtag_active,
  output logic                      busy
);

  logic [CHANNELS*WIDTH-1:0] shadow_data;
  logic [CHANNELS-1:0]       shadow_sel;
  logic [CHANNELS-1:0]       settling;

  // Shadow capture. Data and select requests load together on ijtag_ue,
  // so a channel in IJTAG sees new data exactly one edge after the strobe.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      shadow_data <= '0;
      shadow_sel  <= '0;
    end else if (ijtag_ue) begin
      shadow_data <= ijtag_data_in;
      shadow_sel  <= ijtag_select_in;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    firebird7_in_gate1_data_mux_chan #(
      .WIDTH         (WIDTH),
      .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_chan (
      .ijtag_tck       (ijtag_tck),
      .ijtag_reset     (ijtag_reset),
      .shadow_sel      (shadow_sel[c]),
      .shadow_data     (shadow_data[c*WIDTH +: WIDTH]),
      .functional_data (functional_data_in[c*WIDTH +: WIDTH]),
      .data_out        (data_out[c*WIDTH +: WIDTH]),
      .active          (ijtag_active[c]),
      .settling        (settling[c])
    );
  end

  // busy is high while any channel is mid-switch.
  always_comb begin
    busy = |settling;
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_sync.sv
// Directed bench for the gate1 IJTAG data override mux (WIDTH=19,
// CHANNELS=2, SETTLE_CYCLES=2). Expected settle-window output follows
// FIREBIRD7_IN_GATE1_DATA_MUX_HOLD_EN if it is defined.
module tb_firebird7_in_gate1_tessent_data_mux_sync;

  localparam int W = 19;
  localparam int C = 2;
  localparam int S = 2;

  logic           ijtag_tck;
  logic           ijtag_reset;
  logic           ijtag_ue;
  logic [C-1:0]   ijtag_select_in;
  logic [C*W-1:0] ijtag_data_in;
  logic [C*W-1:0] functional_data_in;
  logic [C*W-1:0] data_out;
  logic [C-1:0]   ijtag_active;
  logic           busy;

  int n_assert = 0;
  int n_fail   = 0;

  firebird7_in_gate1_tessent_data_mux_sync #(
    .WIDTH(W), .CHANNELS(C), .SETTLE_CYCLES(S)
  ) dut (
    .ijtag_tck          (ijtag_tck),
    .ijtag_reset        (ijtag_reset),
    .ijtag_ue           (ijtag_ue),
    .ijtag_select_in    (ijtag_select_in),
    .ijtag_data_in      (ijtag_data_in),
    .functional_data_in (functional_data_in),
    .data_out           (data_out),
    .ijtag_active       (ijtag_active),
    .busy               (busy)
  );

  initial ijtag_tck = 1'b0;
  always #5 ijtag_tck = ~ijtag_tck;

  // Value expected on a channel during a settle window.
  function automatic logic [W-1:0] sv(input logic [W-1:0] held);
`ifdef FIREBIRD7_IN_GATE1_DATA_MUX_HOLD_EN
    return held;
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                         input logic [C-1:0] eact, input logic ebusy);
    chk({tag, "_d0"}, 64'(data_out[0 +: W]), 64'(e0));
    chk({tag, "_d1"}, 64'(data_out[W +: W]), 64'(e1));
    chk({tag, "_act"}, 64'(ijtag_active), 64'(eact));
    chk({tag, "_busy"}, 64'(busy), 64'(ebusy));
  endtask

  task automatic set_f(input logic [W-1:0] f0, input logic [W-1:0] f1);
    functional_data_in = {f1, f0};
  endtask

  task automatic set_i(input logic [W-1:0] i0, input logic [W-1:0] i1);
    ijtag_data_in = {i1, i0};
  endtask

  initial begin
    ijtag_reset     = 1'b0;
    ijtag_ue        = 1'b0;
    ijtag_select_in = '0;
    set_i('0, '0);
    set_f(19'h1ABCD, 19'h12345);
    #3;
    // Reset state
    chk_all("rst", 19'h1ABCD, 19'h12345, 2'b00, 1'b0);
    tick();
    chk_all("rst_clk", 19'h1ABCD, 19'h12345, 2'b00, 1'b0);
    #2 ijtag_reset = 1'b1;
    tick();
    chk_all("post_rst", 19'h1ABCD, 19'h12345, 2'b00, 1'b0);

    // Switch ch0 in
    set_f(19'h0F0F0, 19'h12345);
    set_i(19'h55555, 19'h00000);
    ijtag_select_in = 2'b01;
    ijtag_ue = 1'b1;
    tick();                                  // edge 0
    ijtag_ue = 1'b0;
    chk_all("sw_e0", 19'h0F0F0, 19'h12345, 2'b00, 1'b0);
    tick();                                  // edge 1
    chk_all("sw_e1", sv(19'h0F0F0), 19'h12345, 2'b00, 1'b1);
    set_f(19'h11111, 19'h12345);             // live data moves; hold must not
    tick();                                  // edge 2
    chk_all("sw_e2", sv(19'h0F0F0), 19'h12345, 2'b00, 1'b1);
    tick();                                  // edge 3
    chk_all("sw_e3", 19'h55555, 19'h12345, 2'b01, 1'b0);

    // Data update while in IJTAG
    set_i(19'h7FFFF, 19'h00000);
    ijtag_ue = 1'b1;
    tick();
    ijtag_ue = 1'b0;
    chk_all("upd", 19'h7FFFF, 19'h12345, 2'b01, 1'b0);

    // Reversal mid-settle on ch1
    set_i(19'h7FFFF, 19'h2AAAA);
    ijtag_select_in = 2'b11;
    ijtag_ue = 1'b1;
    tick();                                  // E0
    ijtag_ue = 1'b0;
    tick();                                  // E1: ch1 TO_IJTAG
    chk_all("rev_e1", 19'h7FFFF, sv(19'h12345), 2'b01, 1'b1);
    ijtag_select_in = 2'b01;
    ijtag_ue = 1'b1;
    tick();                                  // E2: release captured, ignored
    ijtag_ue = 1'b0;
    chk_all("rev_e2", 19'h7FFFF, sv(19'h12345), 2'b01, 1'b1);
    tick();                                  // E3: ch1 reaches IJTAG
    chk_all("rev_e3", 19'h7FFFF, 19'h2AAAA, 2'b11, 1'b0);
    tick();                                  // E4: ch1 TO_FUNC
    chk_all("rev_e4", 19'h7FFFF, sv(19'h2AAAA), 2'b01, 1'b1);
    tick();                                  // E5
    chk_all("rev_e5", 19'h7FFFF, sv(19'h2AAAA), 2'b01, 1'b1);
    tick();                                  // E6: ch1 back to FUNC
    chk_all("rev_e6", 19'h7FFFF, 19'h12345, 2'b01, 1'b0);

    // Independence: ch0 out, ch1 in on the same edge
    set_i(19'h7FFFF, 19'h33333);
    ijtag_select_in = 2'b10;
    ijtag_ue = 1'b1;
    tick();                                  // E0
    ijtag_ue = 1'b0;
    chk_all("ind_e0", 19'h7FFFF, 19'h12345, 2'b01, 1'b0);
    tick();                                  // E1
    chk_all("ind_e1", sv(19'h7FFFF), sv(19'h12345), 2'b00, 1'b1);
    tick();                                  // E2
    chk_all("ind_e2", sv(19'h7FFFF), sv(19'h12345), 2'b00, 1'b1);
    tick();                                  // E3
    chk_all("ind_e3", 19'h11111, 19'h33333, 2'b10, 1'b0);

    // Abort: reset during TO_FUNC on ch1
    ijtag_select_in = 2'b00;
    ijtag_ue = 1'b1;
    tick();                                  // E0
    ijtag_ue = 1'b0;
    tick();                                  // E1: ch1 TO_FUNC
    chk_all("abt_e1", 19'h11111, sv(19'h33333), 2'b00, 1'b1);
    #2 ijtag_reset = 1'b0;
    #1;
    chk_all("abt_rst", 19'h11111, 19'h12345, 2'b00, 1'b0);
    #2 ijtag_reset = 1'b1;
    ijtag_select_in = 2'b11;                 // not strobed: shadow_sel stays 0
    tick();
    tick();
    chk_all("abt_post", 19'h11111, 19'h12345, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
